spi_multi_reader: RTL and testbench

SPI_MULTI_READER -- requirements
Module: spi_multi_reader

---
 rtl/spi_reader_pkg.sv | 26 ++
 rtl/spi_rx_shifter.sv | 77 +++++++
 rtl/spi_multi_reader.sv | 158 +++++++++++++++
 tb/tb_spi_multi_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_reader_pkg
// Brief    : Shared scan-FSM encoding and SPI mode constants for spi_multi_reader.
// Revision : 1.0 - initial release
// ============================================================================
package spi_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  localparam logic c_SPI_MODE0_CPOL = 1'b0;
  localparam logic c_SPI_MODE3_CPOL = 1'b1;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int f_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_shifter
// Brief    : Generates DATA_W sclk periods and shifts sdo in MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rx_shifter
  import spi_reader_pkg::*;
#(
  parameter int   DATA_W  = 16,
  parameter int   CLK_DIV = 4,
  parameter logic CPOL    = c_SPI_MODE0_CPOL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_sdo,
  output logic              o_sclk,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(DATA_W - 1);

  logic              r_active;
  logic              r_high;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic              r_sclk;
  logic [DATA_W-1:0] r_shift;
  logic              w_half_end;

  assign w_half_end = r_active && (r_div == c_DIV_LAST);
  assign o_done     = w_half_end && r_high && (r_bit == c_BIT_LAST);
  assign o_sclk     = r_sclk;
  assign o_data     = r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_high   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= CPOL;
      r_shift  <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_high   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
    end else if (w_half_end) begin
      r_div <= '0;
      if (!r_high) begin
        // Low-to-high transition of sclk is the sampling point.
        r_high  <= 1'b1;
        r_sclk  <= 1'b1;
        r_shift <= {r_shift[DATA_W-2:0], i_sdo};
      end else if (o_done) begin
        r_active <= 1'b0;
        r_high   <= 1'b0;
        r_sclk   <= CPOL;
      end else begin
        r_high <= 1'b0;
        r_sclk <= 1'b0;
        r_bit  <= r_bit + BIT_W'(1);
      end
    end else if (r_active) begin
      r_div <= r_div + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_multi_reader.sv
`default_nettype none
// ============================================================================
// Module   : spi_multi_reader
// Brief    : Periodically scans N_CH SPI peripherals and banks their frames.
// Revision : 1.0 - initial release
// ============================================================================
module spi_multi_reader
  import spi_reader_pkg::*;
#(
  parameter int   N_CH           = 2,
  parameter int   DATA_W         = 16,
  parameter int   CLK_DIV        = 4,
  parameter int   REFRESH_PERIOD = 1000,
  parameter logic CPOL           = c_SPI_MODE0_CPOL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trig,
  input  logic                      sdo,
  output logic                      sclk,
  output logic [N_CH-1:0]           cs_n,
  output logic [DATA_W-1:0]         data_o,
  output logic [f_idx_w(N_CH)-1:0]  ch_o,
  output logic                      valid_o,
  output logic [N_CH*DATA_W-1:0]    results_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int CH_W  = f_idx_w(N_CH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int REF_W = $clog2(REFRESH_PERIOD);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [REF_W-1:0] c_REF_LAST = REF_W'(REFRESH_PERIOD - 1);

  logic [REF_W-1:0]  r_refresh_cnt;
  state_t            r_state;
  logic [DIV_W-1:0]  r_phase;
  logic [CH_W-1:0]   r_ch;
  logic              w_tick;
  logic              w_req;
  logic              w_phase_end;
  logic              w_start;
  logic              w_done;
  logic [DATA_W-1:0] w_rx;

  assign w_tick      = (r_refresh_cnt == c_REF_LAST);
  assign w_req       = w_tick | trig;
  assign w_phase_end = (r_phase == c_DIV_LAST);
  assign w_start     = (r_state == ST_CS_SETUP) && w_phase_end;

  // Free-running, so tick spacing never depends on scan activity.
  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + REF_W'(1);
    end
  end

  spi_rx_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_sdo   (sdo),
    .o_sclk  (sclk),
    .o_done  (w_done),
    .o_data  (w_rx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_ch      <= '0;
      cs_n      <= '1;
      data_o    <= '0;
      ch_o      <= '0;
      valid_o   <= 1'b0;
      results_o <= '0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (w_req && busy_o) begin
        overrun_o <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state <= ST_CS_SETUP;
            r_phase <= '0;
            r_ch    <= '0;
            cs_n    <= ~N_CH'(1);
            busy_o  <= 1'b1;
          end
        end
        ST_CS_SETUP: begin
          if (w_phase_end) begin
            r_state <= ST_SHIFT;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (w_done) begin
            r_state <= ST_CS_HOLD;
            r_phase <= '0;
          end
        end
        ST_CS_HOLD: begin
          if (w_phase_end) begin
            r_phase <= '0;
            cs_n    <= '1;
            data_o  <= w_rx;
            ch_o    <= r_ch;
            valid_o <= 1'b1;
            for (int k = 0; k < N_CH; k++) begin
              if (int'(r_ch) == k) begin
                results_o[k*DATA_W +: DATA_W] <= w_rx;
              end
            end
            if (int'(r_ch) < N_CH - 1) begin
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
              busy_o  <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + DIV_W'(1);
          end
        end
        ST_GAP: begin
          if (w_phase_end) begin
            r_state <= ST_CS_SETUP;
            r_phase <= '0;
            r_ch    <= r_ch + CH_W'(1);
            cs_n    <= ~(N_CH'(1) << (r_ch + CH_W'(1)));
          end else begin
            r_phase <= r_phase + DIV_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy_o  <= 1'b0;
          cs_n    <= '1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_multi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_multi_reader
// Brief    : Scoreboard bench with SPI peripheral models for two reader configs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_multi_reader;

  localparam int A_N = 2, A_DW = 16, A_DIV = 2, A_REF = 1000;
  localparam int B_N = 1, B_DW = 12, B_DIV = 3, B_REF = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, trig_a = 1'b0, sdo_a = 1'b0;
  logic rst_b = 1'b1, trig_b = 1'b0, sdo_b = 1'b0;
  logic sclk_a, sclk_b, val_a, val_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [A_N-1:0] cs_a;
  logic [B_N-1:0] cs_b;
  logic [A_DW-1:0] data_a;
  logic [B_DW-1:0] data_b;
  logic [0:0] ch_a, ch_b;
  logic [A_N*A_DW-1:0] res_a;
  logic [B_N*B_DW-1:0] res_b;

  spi_multi_reader #(.N_CH(A_N), .DATA_W(A_DW), .CLK_DIV(A_DIV),
                     .REFRESH_PERIOD(A_REF), .CPOL(1'b0)) u_dut_a (
    .clk(clk), .rst(rst_a), .trig(trig_a), .sdo(sdo_a), .sclk(sclk_a),
    .cs_n(cs_a), .data_o(data_a), .ch_o(ch_a), .valid_o(val_a),
    .results_o(res_a), .busy_o(busy_a), .overrun_o(ovr_a));

  spi_multi_reader #(.N_CH(B_N), .DATA_W(B_DW), .CLK_DIV(B_DIV),
                     .REFRESH_PERIOD(B_REF), .CPOL(1'b1)) u_dut_b (
    .clk(clk), .rst(rst_b), .trig(trig_b), .sdo(sdo_b), .sclk(sclk_b),
    .cs_n(cs_b), .data_o(data_b), .ch_o(ch_b), .valid_o(val_b),
    .results_o(res_b), .busy_o(busy_b), .overrun_o(ovr_b));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct { int ch; logic [31:0] w; } exp_t;
  exp_t q_a[$], q_b[$];

  // Peripheral model A (mode 0): MSB on select, next bit after each falling sclk.
  logic        fixed_a = 1'b0;
  logic [15:0] fix_a [2];
  logic [15:0] word_a = '0;
  logic [15:0] bank_a [2] = '{default: '0};
  int sel_a = -1, nr_a = 0, low_a = 0, nval_a = 0;
  bit abort_a = 1'b0;

  task automatic frame_start_a(input int k);
    word_a  = fixed_a ? fix_a[k] : 16'($urandom);
    sel_a   = k;
    nr_a    = 0;
    low_a   = 0;
    abort_a = 1'b0;
    sdo_a   = word_a[A_DW-1];
    q_a.push_back('{k, {16'h0, word_a}});
  endtask

  task automatic frame_end_a(input int k);
    if (sel_a == k) begin
      if (!abort_a) begin
        chk("a_cs_low_cycles", low_a, A_DIV * (2 * A_DW + 2));
        chk("a_sclk_rises", nr_a, A_DW);
      end
      sel_a = -1;
    end
  endtask

  always @(negedge cs_a[0]) frame_start_a(0);
  always @(negedge cs_a[1]) frame_start_a(1);
  always @(posedge cs_a[0]) frame_end_a(0);
  always @(posedge cs_a[1]) frame_end_a(1);
  always @(posedge sclk_a) if (sel_a >= 0) nr_a++;
  always @(negedge sclk_a) if (sel_a >= 0 && nr_a < A_DW) sdo_a = word_a[A_DW-1-nr_a];

  logic prev_val_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (cs_a != 2'b11) low_a++;
    if (!rst_a) begin
      chk("a_cs_onehot", ($countones(~cs_a) <= 1), 1);
      if (cs_a == 2'b11) chk("a_sclk_idle", sclk_a, 1'b0);
    end
    if (val_a) begin
      nval_a++;
      chk("a_valid_one_cycle", prev_val_a, 0);
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_valid: actual=valid required=no valid");
      end else begin
        e = q_a.pop_front();
        bank_a[e.ch] = e.w[15:0];
        chk("a_ch", ch_a, e.ch);
        chk("a_data", data_a, e.w[15:0]);
        chk("a_results", res_a, {bank_a[1], bank_a[0]});
      end
    end
    prev_val_a = val_a;
  end

  // Peripheral model B (mode 3): first falling sclk presents the MSB again.
  logic [11:0] word_b = '0;
  logic [11:0] bank_b = '0;
  int sel_b = -1, nr_b = 0, low_b = 0, nval_b = 0, last_b = -1, cyc = 0;

  always @(posedge clk) cyc++;
  always @(negedge cs_b[0]) begin
    word_b = 12'($urandom);
    sel_b  = 0;
    nr_b   = 0;
    low_b  = 0;
    sdo_b  = word_b[B_DW-1];
    q_b.push_back('{0, {20'h0, word_b}});
  end
  always @(posedge cs_b[0]) begin
    if (sel_b == 0) begin
      chk("b_cs_low_cycles", low_b, B_DIV * (2 * B_DW + 2));
      chk("b_sclk_rises", nr_b, B_DW);
      sel_b = -1;
    end
  end
  always @(posedge sclk_b) if (sel_b >= 0) nr_b++;
  always @(negedge sclk_b) if (sel_b >= 0 && nr_b < B_DW) sdo_b = word_b[B_DW-1-nr_b];

  always @(negedge clk) begin
    exp_t e;
    if (cs_b != 1'b1) low_b++;
    if (!rst_b && cs_b == 1'b1) chk("b_sclk_idle_high", sclk_b, 1'b1);
    if (val_b) begin
      nval_b++;
      if (last_b >= 0) chk("b_valid_period", cyc - last_b, B_REF);
      last_b = cyc;
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_valid: actual=valid required=no valid");
      end else begin
        e = q_b.pop_front();
        bank_b = e.w[11:0];
        chk("b_ch", ch_b, 0);
        chk("b_data", data_b, e.w[11:0]);
        chk("b_results", res_b, bank_b);
      end
    end
  end

  task automatic pulse_trig_a();
    @(negedge clk);
    trig_a = 1'b1;
    @(negedge clk);
    trig_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int i;
    i = 0;
    while (busy_a && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (busy_a) begin
      total++; bad++;
      $display("FAIL a_scan_timeout: actual=busy required=idle within %0d", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, i;
    fix_a[0] = 16'hA5C3;
    fix_a[1] = 16'h0F0F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("a_rst_sclk", sclk_a, 1'b0);
    chk("a_rst_cs_n", cs_a, 2'b11);
    chk("a_rst_data", data_a, 0);
    chk("a_rst_ch", ch_a, 0);
    chk("a_rst_valid", val_a, 0);
    chk("a_rst_results", res_a, 0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_overrun", ovr_a, 0);
    chk("b_rst_sclk", sclk_b, 1'b1);
    chk("b_rst_cs_n", cs_b, 1'b1);

    // Known words on both channels.
    fixed_a = 1'b1;
    n0 = nval_a;
    pulse_trig_a();
    wait_idle_a(400);
    fixed_a = 1'b0;
    chk("a_directed_results", res_a, 32'h0F0FA5C3);
    chk("a_directed_frames", nval_a - n0, 2);

    // trig during ch0 SHIFT must be dropped and flagged.
    chk("a_overrun_before", ovr_a, 0);
    n0 = nval_a;
    pulse_trig_a();
    repeat (20) @(negedge clk);
    chk("a_in_shift_ch0", cs_a, 2'b10);
    pulse_trig_a();
    chk("a_overrun_set", ovr_a, 1);
    wait_idle_a(400);
    chk("a_overrun_scan_frames", nval_a - n0, 2);

    for (int k = 0; k < 3; k++) begin
      pulse_trig_a();
      wait_idle_a(400);
    end

    // Automatic refresh tick.
    n0 = nval_a;
    i = 0;
    while (nval_a < n0 + 2 && i < 1500) begin
      @(negedge clk);
      i++;
    end
    chk("a_tick_scan_frames", nval_a - n0, 2);
    chk("a_overrun_sticky", ovr_a, 1);

    // Reset in the middle of ch1, bit 7.
    pulse_trig_a();
    i = 0;
    while (!(cs_a[1] == 1'b0 && nr_a == 7) && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("a_reached_ch1_bit7", nr_a, 7);
    abort_a = 1'b1;
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    q_a.delete();
    bank_a[0] = '0;
    bank_a[1] = '0;
    @(negedge clk);
    chk("a_abort_cs_n", cs_a, 2'b11);
    chk("a_abort_sclk", sclk_a, 1'b0);
    chk("a_abort_results", res_a, 0);
    chk("a_abort_valid", val_a, 0);
    chk("a_abort_overrun", ovr_a, 0);
    rst_a = 1'b0;
    n0 = nval_a;
    repeat (200) @(negedge clk);
    chk("a_no_valid_after_abort", nval_a - n0, 0);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_enough_frames", (nval_b >= 5), 1);
    chk("b_overrun_clear", ovr_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
